seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexing controller for the board's dual seven-segment display.
- One shared seg_disp decoder serves two hex digits: s0 on the right display, s1 on the left.
- The block selects which nibble feeds the decoder and drives the two active-low digit-enable (anode/PNP) lines.
- It inserts blanking between digits to prevent ghosting, and latches both inputs once per frame so each frame is coherent.

Parameters:
DIGIT_CYCLES, 96000, clk cycles each digit is lit (48 MHz HSOSC -> 2 ms). Legal range >=1.
BLANK_CYCLES, 4800, clk cycles both digits are dark before each digit (100 us). Legal range >=1.

Ports:
clk  input  1  system clock (HSOSC, 48 MHz)
reset  input  1  synchronous, active-high reset
en  input  1  display enable; 0 forces both digits dark
s0  input  4  hex value for digit 0 (right)
s1  input  4  hex value for digit 1 (left)
nib  output  4  nibble routed to the shared seg_disp decoder
an_n  output  2  active-low digit enables; an_n[0] = digit 0, an_n[1] = digit 1
digit_sel  output  1  index of the digit currently addressed (0/1)
frame_done  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- All outputs are registered and update on the same edge as the state register.
- FSM states, in a ring: BLANK1 -> SHOW0 -> BLANK0 -> SHOW1 -> BLANK1.
  - BLANKx lasts exactly BLANK_CYCLES cycles.
  - SHOWx lasts exactly DIGIT_CYCLES cycles.
  - Frame length = 2*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
- Dwell counter:
  - Width $clog2(max(DIGIT_CYCLES,BLANK_CYCLES)+1).
  - Clears on every state transition.
  - Transition occurs on the edge where counter == dwell-1.
  - No wrap beyond the dwell value.
- Shadow registers sh0/sh1:
  - Load s0/s1 on every cycle while reset is high.
  - Load again on the SHOW1->BLANK1 edge.
  - Never load otherwise; mid-frame input changes are invisible until the next frame.
- Outputs by state:
  - BLANK1: nib = sh0, digit_sel = 0, an_n = 11 (decoder pre-settles on the next digit).
  - SHOW0: nib = sh0, digit_sel = 0, an_n = {1,~en_q}.
  - BLANK0: nib = sh1, digit_sel = 1, an_n = 11.
  - SHOW1: nib = sh1, digit_sel = 1, an_n = {~en_q,1}.
  - en_q is en registered once. Dropping en darkens the lit digit on the 2nd edge after en falls; raising en lights it on the 2nd edge after en rises.
  - The FSM keeps running while en = 0.
- Both an_n bits are never simultaneously 0, in any state, including during reset or the first cycle after reset.
- frame_done:
  - High only during the first cycle of BLANK1 entered from SHOW1.
  - Not asserted on the BLANK1 that follows reset.
- Reset values: state BLANK1, counter 0, an_n 11, digit_sel 0, frame_done 0, en_q 0, nib = current sh0.
- Reset asserted mid-state: on the next edge, abandon the current dwell and force the reset values. A partially shown digit is acceptable; a both-lit glitch is not.

Test Plan:
1. DIGIT_CYCLES=4, BLANK_CYCLES=2, en=1, s0=3, s1=A; reset high 3 cycles, then low (cycle 0 = first cycle low). Required response:
   - cycles 0-1: an_n=11, nib=3.
   - cycles 2-5: an_n=10, nib=3.
   - cycles 6-7: an_n=11, nib=A.
   - cycles 8-11: an_n=01, nib=A.
   - cycle 12: frame_done=1, an_n=11.
   - Pattern repeats with period 12.
2. Same setup; s0 changes to 7 at cycle 3 -> nib stays 3 through cycle 11; cycles 14-17 show nib=7 with an_n=10.
3. en driven low at cycle 3 -> an_n=11 from cycle 5; state sequence and frame_done timing unchanged. en high at cycle 8 -> an_n=01 from cycle 10.
4. Reset reasserted at cycle 9 (during SHOW1) for 1 cycle -> an_n=11 the next cycle; timeline restarts per scenario 1; no frame_done at the restart.
5. DIGIT_CYCLES=1, BLANK_CYCLES=1 -> an_n sequence 11,10,11,01 repeating with period 4; frame_done every 4th cycle; counter never exceeds 0.
6. Random s0/s1/en/reset for 10k cycles, default-scaled-down params -> assertion an_n != 00 always holds; frame_done spacing is exactly 2*(D+B) between resets.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Dual seven-segment scan controller: one shared decoder, blanking between digits, per-frame input latch.
// Outputs registered on the state edge; en acts two edges after it changes; no backpressure.
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 96000,
  parameter int BLANK_CYCLES = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] nib,
  output logic [1:0] an_n,
  output logic       digit_sel,
  output logic       frame_done
);

  localparam int MAX_DWELL = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_DWELL + 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {BLANK1, SHOW0, BLANK0, SHOW1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    sh0;
  logic [3:0]    sh1;
  logic          en_q;
  logic          last;

  assign last = (state == SHOW0 || state == SHOW1) ? (cnt == DIGIT_LAST) : (cnt == BLANK_LAST);

  // an_n is always derived from the state being entered, and each show state
  // drives only its own bit, so the two enables can never be low together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK1;
      cnt        <= '0;
      sh0        <= s0;
      sh1        <= s1;
      en_q       <= 1'b0;
      nib        <= s0;
      an_n       <= 2'b11;
      digit_sel  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      en_q       <= en;
      frame_done <= 1'b0;
      if (!last) begin
        cnt <= cnt + CW'(1);
        unique case (state)
          SHOW0:   an_n <= {1'b1, ~en_q};
          SHOW1:   an_n <= {~en_q, 1'b1};
          BLANK1:  an_n <= 2'b11;
          BLANK0:  an_n <= 2'b11;
        endcase
      end else begin
        cnt <= '0;
        unique case (state)
          BLANK1: begin
            state <= SHOW0;
            an_n  <= {1'b1, ~en_q};
          end
          SHOW0: begin
            state     <= BLANK0;
            nib       <= sh1;
            digit_sel <= 1'b1;
            an_n      <= 2'b11;
          end
          BLANK0: begin
            state <= SHOW1;
            an_n  <= {~en_q, 1'b1};
          end
          SHOW1: begin
            // Frame boundary: take a fresh coherent snapshot of both digits.
            state      <= BLANK1;
            sh0        <= s0;
            sh1        <= s1;
            nib        <= s0;
            digit_sel  <= 1'b0;
            an_n       <= 2'b11;
            frame_done <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and randomized checks of seg_scan_ctrl: scan timeline, frame latching, enable delay, reset, minimum dwell.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, en_a, digit_sel_a, frame_done_a;
  logic [3:0] s0_a, s1_a, nib_a;
  logic [1:0] an_n_a;

  logic       reset_b, en_b, digit_sel_b, frame_done_b;
  logic [3:0] s0_b, s1_b, nib_b;
  logic [1:0] an_n_b;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset_a), .en(en_a), .s0(s0_a), .s1(s1_a),
    .nib(nib_a), .an_n(an_n_a), .digit_sel(digit_sel_a), .frame_done(frame_done_a)
  );

  seg_scan_ctrl #(.DIGIT_CYCLES(1), .BLANK_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .s0(s0_b), .s1(s1_b),
    .nib(nib_b), .an_n(an_n_b), .digit_sel(digit_sel_b), .frame_done(frame_done_b)
  );

  // 0=BLANK1 1=SHOW0 2=BLANK0 3=SHOW1 for D=4, B=2 (frame of 12 cycles)
  function automatic int phase_a(input int rel);
    int p;
    p = rel % 12;
    if (p < 2) return 0;
    if (p < 6) return 1;
    if (p < 8) return 2;
    return 3;
  endfunction

  function automatic logic en_sched(input int t);
    return !(t >= 3 && t < 8);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a_for(input int n);
    reset_a = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset_a = 1'b0;
  endtask

  task automatic test_reset();
    s0_a = 4'h9; s1_a = 4'h2; en_a = 1'b1; reset_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (an_n_a !== 2'b11) begin errors++; $display("FAIL reset_an_n got %b want 11", an_n_a); end
    checks++; if (digit_sel_a !== 1'b0) begin errors++; $display("FAIL reset_digit_sel got %b want 0", digit_sel_a); end
    checks++; if (frame_done_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done_a); end
    checks++; if (nib_a !== 4'h9) begin errors++; $display("FAIL reset_nib got %h want 9", nib_a); end
    s0_a = 4'h4;
    next_cycle();
    @(negedge clk);
    checks++; if (nib_a !== 4'h4) begin errors++; $display("FAIL reset_nib_follow got %h want 4", nib_a); end
    checks++; if (an_n_a !== 2'b11) begin errors++; $display("FAIL reset_an_n_hold got %b want 11", an_n_a); end
    next_cycle();
  endtask

  task automatic test_scan();
    int ph;
    logic [1:0] ean;
    logic [3:0] enib;
    s0_a = 4'h3; s1_a = 4'hA; en_a = 1'b1;
    reset_a_for(3);
    for (int t = 0; t < 36; t++) begin
      ph   = phase_a(t);
      ean  = (ph == 1) ? 2'b10 : (ph == 3) ? 2'b01 : 2'b11;
      enib = (ph < 2) ? 4'h3 : 4'hA;
      @(negedge clk);
      checks++; if (an_n_a !== ean) begin errors++; $display("FAIL scan_an_n cycle %0d got %b want %b", t, an_n_a, ean); end
      checks++; if (nib_a !== enib) begin errors++; $display("FAIL scan_nib cycle %0d got %h want %h", t, nib_a, enib); end
      checks++; if (digit_sel_a !== (ph >= 2)) begin errors++; $display("FAIL scan_digit_sel cycle %0d got %b want %b", t, digit_sel_a, (ph >= 2)); end
      checks++; if (frame_done_a !== (t > 0 && t % 12 == 0)) begin errors++; $display("FAIL scan_frame_done cycle %0d got %b want %b", t, frame_done_a, (t > 0 && t % 12 == 0)); end
      next_cycle();
    end
  endtask

  task automatic test_frame_latch();
    int ph;
    logic [1:0] ean;
    logic [3:0] enib;
    s0_a = 4'h3; s1_a = 4'hA; en_a = 1'b1;
    reset_a_for(3);
    for (int t = 0; t < 26; t++) begin
      if (t == 3) s0_a = 4'h7;
      ph   = phase_a(t);
      ean  = (ph == 1) ? 2'b10 : (ph == 3) ? 2'b01 : 2'b11;
      enib = (ph < 2) ? ((t < 12) ? 4'h3 : 4'h7) : 4'hA;
      @(negedge clk);
      checks++; if (nib_a !== enib) begin errors++; $display("FAIL latch_nib cycle %0d got %h want %h", t, nib_a, enib); end
      checks++; if (an_n_a !== ean) begin errors++; $display("FAIL latch_an_n cycle %0d got %b want %b", t, an_n_a, ean); end
      next_cycle();
    end
  endtask

  task automatic test_enable();
    int ph;
    logic lit;
    logic [1:0] ean;
    s0_a = 4'h3; s1_a = 4'hA; en_a = 1'b1;
    reset_a_for(3);
    for (int t = 0; t < 28; t++) begin
      en_a = en_sched(t);
      ph   = phase_a(t);
      lit  = (t >= 2) && en_sched(t - 2);
      ean  = (ph == 1 && lit) ? 2'b10 : (ph == 3 && lit) ? 2'b01 : 2'b11;
      @(negedge clk);
      checks++; if (an_n_a !== ean) begin errors++; $display("FAIL enable_an_n cycle %0d got %b want %b", t, an_n_a, ean); end
      checks++; if (frame_done_a !== (t > 0 && t % 12 == 0)) begin errors++; $display("FAIL enable_frame_done cycle %0d got %b want %b", t, frame_done_a, (t > 0 && t % 12 == 0)); end
      next_cycle();
    end
    en_a = 1'b1;
  endtask

  task automatic test_reset_mid();
    int ph, rel;
    logic [1:0] ean;
    logic efd;
    s0_a = 4'h3; s1_a = 4'hA; en_a = 1'b1;
    reset_a_for(3);
    for (int t = 0; t < 36; t++) begin
      reset_a = (t == 9);
      rel = (t < 10) ? t : t - 10;
      ph  = phase_a(rel);
      ean = (ph == 1) ? 2'b10 : (ph == 3) ? 2'b01 : 2'b11;
      efd = (rel > 0) && (rel % 12 == 0);
      @(negedge clk);
      checks++; if (an_n_a !== ean) begin errors++; $display("FAIL rstmid_an_n cycle %0d got %b want %b", t, an_n_a, ean); end
      checks++; if (frame_done_a !== efd) begin errors++; $display("FAIL rstmid_frame_done cycle %0d got %b want %b", t, frame_done_a, efd); end
      next_cycle();
    end
    reset_a = 1'b0;
  endtask

  task automatic test_min_dwell();
    int ph;
    logic [1:0] ean;
    logic [3:0] enib;
    s0_b = 4'h5; s1_b = 4'hC; en_b = 1'b1; reset_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b0;
    for (int t = 0; t < 20; t++) begin
      ph   = t % 4;
      ean  = (ph == 1 && t >= 2) ? 2'b10 : (ph == 3) ? 2'b01 : 2'b11;
      enib = (ph < 2) ? 4'h5 : 4'hC;
      @(negedge clk);
      checks++; if (an_n_b !== ean) begin errors++; $display("FAIL min_an_n cycle %0d got %b want %b", t, an_n_b, ean); end
      checks++; if (nib_b !== enib) begin errors++; $display("FAIL min_nib cycle %0d got %h want %h", t, nib_b, enib); end
      checks++; if (frame_done_b !== (t > 0 && t % 4 == 0)) begin errors++; $display("FAIL min_frame_done cycle %0d got %b want %b", t, frame_done_b, (t > 0 && t % 4 == 0)); end
      checks++; if (dut_b.cnt !== '0) begin errors++; $display("FAIL min_cnt cycle %0d got %0d want 0", t, dut_b.cnt); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int ph, rel;
    logic [3:0] sh0m, sh1m, enib;
    logic [1:0] ean;
    logic enq_cur, enq_prev, efd;
    s0_a = 4'($urandom_range(15)); s1_a = 4'($urandom_range(15)); en_a = 1'b1;
    reset_a_for(2);
    rel = 0; sh0m = s0_a; sh1m = s1_a; enq_cur = 1'b0; enq_prev = 1'b0;
    for (int t = 0; t < 10000; t++) begin
      s0_a    = 4'($urandom_range(15));
      s1_a    = 4'($urandom_range(15));
      en_a    = ($urandom_range(3) != 0);
      reset_a = ($urandom_range(299) == 0);
      ph   = phase_a(rel);
      ean  = (ph == 1 && enq_prev) ? 2'b10 : (ph == 3 && enq_prev) ? 2'b01 : 2'b11;
      enib = (ph < 2) ? sh0m : sh1m;
      efd  = (rel > 0) && (rel % 12 == 0);
      @(negedge clk);
      checks++; if (an_n_a === 2'b00) begin errors++; $display("FAIL rand_both_lit cycle %0d got %b want not 00", t, an_n_a); end
      checks++; if (an_n_a !== ean) begin errors++; $display("FAIL rand_an_n cycle %0d got %b want %b", t, an_n_a, ean); end
      checks++; if (nib_a !== enib) begin errors++; $display("FAIL rand_nib cycle %0d got %h want %h", t, nib_a, enib); end
      checks++; if (digit_sel_a !== (ph >= 2)) begin errors++; $display("FAIL rand_digit_sel cycle %0d got %b want %b", t, digit_sel_a, (ph >= 2)); end
      checks++; if (frame_done_a !== efd) begin errors++; $display("FAIL rand_frame_done cycle %0d got %b want %b", t, frame_done_a, efd); end
      if (reset_a) begin
        rel = 0; sh0m = s0_a; sh1m = s1_a;
      end else begin
        if (rel % 12 == 11) begin sh0m = s0_a; sh1m = s1_a; end
        rel++;
      end
      enq_prev = enq_cur;
      enq_cur  = reset_a ? 1'b0 : en_a;
      next_cycle();
    end
    reset_a = 1'b0;
  endtask

  initial begin
    reset_a = 1'b1; en_a = 1'b0; s0_a = 4'h0; s1_a = 4'h0;
    reset_b = 1'b1; en_b = 1'b0; s0_b = 4'h0; s1_b = 4'h0;
    test_reset();
    test_scan();
    test_frame_latch();
    test_enable();
    test_reset_mid();
    test_min_dwell();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
